// File: rtl/div_pkg.sv
// Shared definitions for the iterative divide controller: width, op encodings, FSM states.
package div_pkg;

  localparam int DIV_XLEN = 32;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // DIV and REM are the signed ops (funct3 bit 0 clear)
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the next dividend bit into the partial remainder, subtract if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic          fits;

  // rem_i < dvs_i keeps rem_sh below 2*dvs_i, so bit XLEN of diff is a clean borrow flag
  always_comb begin
    rem_sh = {rem_i, quo_i[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_i};
    fits   = ~diff[XLEN];
    rem_o  = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_o  = {quo_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU unit for the EX stage; stalls the pipe while iterating.
// Optional DIV_CTRL_EARLY_OUT_EN: divide-by-zero skips the iteration and completes the cycle after issue.
//
// state | meaning
// IDLE  | waiting for starte; captures operands on issue
// BUSY  | one quotient bit per cycle, 32 cycles
// DONE  | result presented for one cycle with donediv
module div_ctrl
  import div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            starte,
  input  logic [1:0]      funct3e,
  input  logic [XLEN-1:0] srcae,
  input  logic [XLEN-1:0] srcbe,
  input  logic            flushe,
  output logic            stalldiv,
  output logic            donediv,
  output logic [XLEN-1:0] resultdiv
);

  div_state_e      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            rem_op_q, rem_op_d;
  logic            dvz_q, dvz_d;

  logic [XLEN-1:0] step_rem, step_quo;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] quo_res, rem_res;
  logic            sgn, issue;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    sgn   = op_is_signed(funct3e);
    a_abs = (sgn && srcae[XLEN-1]) ? (~srcae + 1'b1) : srcae;
    b_abs = (sgn && srcbe[XLEN-1]) ? (~srcbe + 1'b1) : srcbe;
    issue = (state_q == S_IDLE) && starte && !flushe;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    dividend_d = dividend_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    rem_op_d   = rem_op_q;
    dvz_d      = dvz_q;

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          cnt_d      = '0;
          rem_d      = '0;
          quo_d      = a_abs;
          dvs_d      = b_abs;
          dividend_d = srcae;
          neg_quo_d  = sgn && (srcae[XLEN-1] ^ srcbe[XLEN-1]);
          neg_rem_d  = sgn && srcae[XLEN-1];
          rem_op_d   = op_is_rem(funct3e);
          dvz_d      = (srcbe == '0);
`ifdef DIV_CTRL_EARLY_OUT_EN
          state_d    = (srcbe == '0) ? S_DONE : S_BUSY;
`else
          state_d    = S_BUSY;
`endif
        end
      end
      S_BUSY: begin
        if (flushe) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      dividend_q <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      rem_op_q   <= 1'b0;
      dvz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      dividend_q <= dividend_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      rem_op_q   <= rem_op_d;
      dvz_q      <= dvz_d;
    end
  end

  // Divide-by-zero overrides the iterated values; the overflow case falls out of the magnitude math
  always_comb begin
    quo_res = dvz_q ? '1 : (neg_quo_q ? (~quo_q + 1'b1) : quo_q);
    rem_res = dvz_q ? dividend_q : (neg_rem_q ? (~rem_q + 1'b1) : rem_q);
  end

  always_comb begin
    stalldiv  = !reset && (issue || (state_q == S_BUSY));
    donediv   = !reset && (state_q == S_DONE) && !flushe;
    resultdiv = donediv ? (rem_op_q ? rem_res : quo_res) : '0;
  end

endmodule
